aes_key_sched_iter: RTL

AES_KEY_SCHED_ITER -- requirements
Module: aes_key_sched_iter

---
 rtl/aes_key_sched_iter_pkg.sv | 33 +++
 rtl/aes_key_sched_iter_word.sv | 24 ++
 rtl/aes_key_sched_iter.sv | 129 ++++++++++++
 3 files changed

// File: rtl/aes_key_sched_iter_pkg.sv
// aes_key_sched_iter_pkg: AES key-length codes, FSM states, S-box, Rcon and word helpers
package aes_key_sched_iter_pkg;

    typedef enum logic [1:0] {KL_128 = 2'd0, KL_192 = 2'd1, KL_256 = 2'd2, KL_BAD = 2'd3} key_len_e;
    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_e;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Index 0 and 11..15 are never used by a legal schedule.
    localparam logic [0:15][7:0] RCON = {88'h00_01_02_04_08_10_20_40_80_1b_36, 40'h0};

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        return RCON[idx];
    endfunction

endpackage

// File: rtl/aes_key_sched_iter_word.sv
// aes_key_word: combinational next-word function of the AES key expansion
module aes_key_word
    import aes_key_sched_iter_pkg::*;
(
    input  logic [31:0] w_prev,
    input  logic [31:0] w_nk,
    input  logic [5:0]  i,
    input  logic [3:0]  nk,
    output logic [31:0] w_next
);

    logic [3:0]  q;
    logic [3:0]  r;
    logic [31:0] t;

    always_comb begin
        q = nk == 4'd4 ? i[5:2] : nk == 4'd8 ? {1'b0, i[5:3]} : 4'(i / 6'd6);
        r = nk == 4'd4 ? {2'b0, i[1:0]} : nk == 4'd8 ? {1'b0, i[2:0]} : 4'(i % 6'd6);
        t = r == 4'd0 ? sub_word(rot_word(w_prev)) ^ {rcon(q), 24'h0}
          : (nk == 4'd8 && r == 4'd4) ? sub_word(w_prev) : w_prev;
        w_next = w_nk ^ t;
    end

endmodule

// File: rtl/aes_key_sched_iter.sv
// aes_key_sched_iter: iterative AES-128/192/256 key expansion, one word per clock, with round-key read port
module aes_key_sched_iter
    import aes_key_sched_iter_pkg::*;
#(
    parameter int NK_MAX = 8,
    parameter int NR_MAX = NK_MAX + 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [1:0]            key_len,
    input  logic [32*NK_MAX-1:0]  key,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  key_valid,
    output logic [3:0]            nr,
    input  logic [3:0]            rd_idx,
    output logic [127:0]          rd_key
);

    localparam int NW = 4 * (NR_MAX + 1);
    localparam int IW = $clog2(NK_MAX);
    localparam logic [3:0] NKM = 4'(NK_MAX);

    state_e      state_q, state_d;
    logic [3:0]  nk_q, nk_d, nrl_q, nrl_d, nr_q, nr_d;
    logic [5:0]  i_q, i_d;
    logic        busy_q, busy_d, done_q, done_d, err_q, err_d, kv_q, kv_d;
    logic [31:0] win_q [NK_MAX];
    logic [31:0] win_d [NK_MAX];
    logic [31:0] mem_q [NW];
    logic [31:0] mem_d [NW];
    logic [31:0] w_next;
    logic [3:0]  req_nk;
    logic        legal;

    assign req_nk = key_len == KL_192 ? 4'd6 : key_len == KL_256 ? 4'd8 : 4'd4;
    assign legal  = key_len != KL_BAD && req_nk <= NKM;

    // Window is oldest-first: win[0] = w[i-Nk], win[Nk-1] = w[i-1].
    aes_key_word u_word (
        .w_prev (win_q[IW'(nk_q - 4'd1)]),
        .w_nk   (win_q[0]),
        .i      (i_q),
        .nk     (nk_q),
        .w_next (w_next)
    );

    always_comb begin
        state_d = state_q;
        nk_d    = nk_q;
        nrl_d   = nrl_q;
        nr_d    = nr_q;
        i_d     = i_q;
        kv_d    = kv_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        win_d   = win_q;
        mem_d   = mem_q;
        if (state_q == IDLE && start && !legal) begin
            err_d = 1'b1;
        end else if (state_q == IDLE && start) begin
            state_d = EXPAND;
            nk_d    = req_nk;
            nrl_d   = req_nk + 4'd6;
            i_d     = {2'b0, req_nk};
            kv_d    = 1'b0;
            for (int j = 0; j < NK_MAX; j++) begin
                win_d[j] = key[32*j +: 32];
                if (j < int'(req_nk)) mem_d[j] = key[32*j +: 32];
            end
        end else if (state_q == EXPAND) begin
            mem_d[i_q] = w_next;
            i_d        = i_q + 6'd1;
            for (int j = 0; j < NK_MAX - 1; j++) win_d[j] = win_q[j+1];
            win_d[IW'(nk_q - 4'd1)] = w_next;
            if (i_q == {nrl_q, 2'b11}) begin
                state_d = DONE;
                done_d  = 1'b1;
                kv_d    = 1'b1;
                nr_d    = nrl_q;
            end
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            nk_q    <= '0;
            nrl_q   <= '0;
            nr_q    <= '0;
            i_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            kv_q    <= 1'b0;
            win_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            nk_q    <= nk_d;
            nrl_q   <= nrl_d;
            nr_q    <= nr_d;
            i_q     <= i_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            kv_q    <= kv_d;
            win_q   <= win_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign key_valid = kv_q;
    assign nr        = nr_q;
    assign rd_key    = (kv_q && rd_idx <= nr_q)
                     ? {mem_q[{rd_idx, 2'b11}], mem_q[{rd_idx, 2'b10}], mem_q[{rd_idx, 2'b01}], mem_q[{rd_idx, 2'b00}]}
                     : '0;

endmodule
